// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: optype and forward-select codes,
// the tracker-entry layout and the source-match helpers.
package hazard_pkg;

    localparam int TRK_RD_W = 5;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [1:0] FWD_REGF    = 2'b00;
    localparam logic [1:0] FWD_EX_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    typedef struct packed {
        logic [1:0]          optype;
        logic [TRK_RD_W-1:0] rd;
        logic                ls_fwd;
    } trk_entry_t;

    localparam trk_entry_t TRK_BUBBLE = '{optype: OP_NONE, rd: '0, ls_fwd: 1'b0};

    // Only ALU and LOAD entries produce a register value; x0 never matches.
    function automatic logic src_hit(input logic used,
                                     input logic [TRK_RD_W-1:0] rs,
                                     input trk_entry_t e);
        return used && (rs != '0) && (rs == e.rd) &&
               ((e.optype == OP_ALU) || (e.optype == OP_LOAD));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem,
                                           input logic [1:0] ex_op,
                                           input logic [1:0] mem_op);
        if (hit_ex && ex_op == OP_ALU)         return FWD_EX_ALU;
        else if (hit_mem && mem_op == OP_ALU)  return FWD_MEM_ALU;
        else if (hit_mem && mem_op == OP_LOAD) return FWD_MEM_LD;
        else                                   return FWD_REGF;
    endfunction

endpackage

// File: rtl/hazard_tracker.sv
// Three-entry EX/MEM/WB record of in-flight instructions; advances every
// clock and inserts a bubble into EX when the ID instruction is stalled.
module hazard_tracker
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bubble_i,
    input  trk_entry_t entry_i,
    output trk_entry_t ex_o,
    output trk_entry_t mem_o,
    output trk_entry_t wb_o
);

    trk_entry_t ex_q, mem_q, wb_q;
    trk_entry_t ex_d;

    // NOTE: every always_comb output gets a value on every path (here via the
    // ternary) so no latch can be inferred.
    always_comb begin
        ex_d = bubble_i ? TRK_BUBBLE : entry_i;
    end

    // NOTE: state uses non-blocking assignments so all three stages shift on
    // the same edge from their pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= TRK_BUBBLE;
            mem_q <= TRK_BUBBLE;
            wb_q  <= TRK_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard detection and forwarding control for the 5-stage RV32I core.
// Full forwarding is built when HAZARD_FWD_EN is defined; otherwise it interlocks only.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        hazard_optype_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic              Branch_ID,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic [1:0]        forward_ctrl_A,
    output logic [1:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls
);

    trk_entry_t ex_e, mem_e, wb_e, id_entry;
    logic hit1_ex, hit2_ex, hit1_mem, hit2_mem;
    logic stall, st_data;

    assign hit1_ex  = src_hit(rs1use_ID, rs1_ID, ex_e);
    assign hit2_ex  = src_hit(rs2use_ID, rs2_ID, ex_e);
    assign hit1_mem = src_hit(rs1use_ID, rs1_ID, mem_e);
    assign hit2_mem = src_hit(rs2use_ID, rs2_ID, mem_e);

`ifdef HAZARD_FWD_EN
    // A store whose data comes from the load in EX can proceed: the data is
    // forwarded from MEM one cycle later, in EX.
    assign st_data = (hazard_optype_ID == OP_STORE) && hit2_ex && !hit1_ex &&
                     (ex_e.optype == OP_LOAD);
    assign stall   = (hit1_ex || hit2_ex) && (ex_e.optype == OP_LOAD) && !st_data;

    assign forward_ctrl_A  = fwd_sel(hit1_ex, hit1_mem, ex_e.optype, mem_e.optype);
    assign forward_ctrl_B  = st_data ? FWD_REGF
                                     : fwd_sel(hit2_ex, hit2_mem, ex_e.optype, mem_e.optype);
    assign forward_ctrl_ls = ex_e.ls_fwd;

    logic unused_trk;
    assign unused_trk = ^{wb_e, mem_e.ls_fwd};
`else
    assign st_data = 1'b0;
    assign stall   = hit1_ex || hit2_ex || hit1_mem || hit2_mem;

    assign forward_ctrl_A  = FWD_REGF;
    assign forward_ctrl_B  = FWD_REGF;
    assign forward_ctrl_ls = 1'b0;

    logic unused_trk;
    assign unused_trk = ^{wb_e, mem_e.ls_fwd, ex_e.ls_fwd};
`endif

    assign PC_EN_IF     = !stall;
    assign reg_FD_EN    = !stall;
    assign reg_DE_flush = stall;
    // A branch resolved on a stale operand must not redirect.
    assign reg_FD_flush = Branch_ID && !stall;

    assign id_entry = '{optype: hazard_optype_ID, rd: rd_ID, ls_fwd: st_data};

    hazard_tracker u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .bubble_i (stall),
        .entry_i  (id_entry),
        .ex_o     (ex_e),
        .mem_o    (mem_e),
        .wb_o     (wb_e)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// instruction streams compared against an instruction-level pipeline model.
module tb_hazard_unit;

    localparam logic [1:0] NONE = 2'd0, ALU = 2'd1, LOAD = 2'd2, STORE = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] op_id;
    logic [4:0] rd_id, rs1_id, rs2_id;
    logic       u1_id, u2_id, br_id;
    logic       pc_en, fd_en, fd_flush, de_flush, fwd_ls;
    logic [1:0] fwd_a, fwd_b;

    hazard_unit #(.REG_AW(5)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hazard_optype_ID (op_id),
        .rd_ID            (rd_id),
        .rs1_ID           (rs1_id),
        .rs2_ID           (rs2_id),
        .rs1use_ID        (u1_id),
        .rs2use_ID        (u2_id),
        .Branch_ID        (br_id),
        .PC_EN_IF         (pc_en),
        .reg_FD_EN        (fd_en),
        .reg_FD_flush     (fd_flush),
        .reg_DE_flush     (de_flush),
        .forward_ctrl_A   (fwd_a),
        .forward_ctrl_B   (fwd_b),
        .forward_ctrl_ls  (fwd_ls)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-level model: what each downstream stage holds.
    typedef struct {
        logic [1:0] op;
        logic [4:0] rd;
        bit         ls;
    } inst_t;

    inst_t pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
    bit         e_stall, e_sd, e_ls;
    logic [1:0] e_fa, e_fb;

    function automatic bit produces(inst_t p, logic [4:0] rs, logic used);
        return used && rs != 0 && p.rd == rs && (p.op == ALU || p.op == LOAD);
    endfunction

    function automatic logic [1:0] source_of(logic [4:0] rs, logic used);
        if (produces(pipe[0], rs, used) && pipe[0].op == ALU) return 2'd1;
        if (produces(pipe[1], rs, used)) return (pipe[1].op == ALU) ? 2'd2 : 2'd3;
        return 2'd0;
    endfunction

    task automatic model_expect();
        bit h1e, h2e, h1m, h2m;
        h1e = produces(pipe[0], rs1_id, u1_id);
        h2e = produces(pipe[0], rs2_id, u2_id);
        h1m = produces(pipe[1], rs1_id, u1_id);
        h2m = produces(pipe[1], rs2_id, u2_id);
`ifdef HAZARD_FWD_EN
        e_sd    = op_id == STORE && h2e && !h1e && pipe[0].op == LOAD;
        e_stall = pipe[0].op == LOAD && (h1e || h2e) && !e_sd;
        e_fa    = source_of(rs1_id, u1_id);
        e_fb    = e_sd ? 2'd0 : source_of(rs2_id, u2_id);
        e_ls    = pipe[0].ls;
`else
        e_sd    = 0;
        e_stall = h1e || h2e || h1m || h2m;
        e_fa    = 2'd0;
        e_fb    = 2'd0;
        e_ls    = 0;
`endif
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{op: NONE, rd: 5'd0, ls: 0};
    endtask

    task automatic set_id(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2, input logic br);
        op_id = op; rd_id = rd; rs1_id = rs1; rs2_id = rs2;
        u1_id = u1; u2_id = u2; br_id = br;
    endtask

    // Compute expectations, sample at the falling edge and compare.
    task automatic eval();
        model_expect();
        @(negedge clk);
        check("pc_en",    pc_en,    !e_stall);
        check("fd_en",    fd_en,    !e_stall);
        check("de_flush", de_flush, e_stall);
        check("fd_flush", fd_flush, br_id && !e_stall);
        check("fwd_a",    fwd_a,    e_fa);
        check("fwd_b",    fwd_b,    e_fb);
        check("fwd_ls",   fwd_ls,   e_ls);
    endtask

    task automatic advance();
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (e_stall) pipe[0] = '{op: NONE, rd: 5'd0, ls: 0};
        else         pipe[0] = '{op: op_id, rd: rd_id, ls: e_sd};
        #1;
    endtask

    task automatic step();
        eval();
        advance();
    endtask

    task automatic nop();
        set_id(NONE, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(ALU, 5'd3, 5'd3, 5'd3, 1, 1, 1'b0);
        model_clear();
        #12;
        check("rst_pc_en", pc_en, 1);
        check("rst_fd_en", fd_en, 1);
        check("rst_de_flush", de_flush, 0);
        check("rst_fd_flush", fd_flush, 0);
        check("rst_fwd_a", fwd_a, 0);
        check("rst_fwd_b", fwd_b, 0);
        check("rst_fwd_ls", fwd_ls, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        nop(); nop(); nop();

        // ALU back-to-back: addi x5 ; add x6,x5,x5
        set_id(ALU, 5'd5, 5'd1, 5'd0, 1, 0, 0); step();
        set_id(ALU, 5'd6, 5'd5, 5'd5, 1, 1, 0); eval();
`ifdef HAZARD_FWD_EN
        check("alu_b2b_a", fwd_a, 2'd1);
        check("alu_b2b_b", fwd_b, 2'd1);
        check("alu_b2b_pc", pc_en, 1);
`else
        check("nofwd_stall1", pc_en, 0);
        advance(); eval();
        check("nofwd_stall2", pc_en, 0);
        advance(); eval();
        check("nofwd_release", pc_en, 1);
        check("nofwd_sel", fwd_a, 2'd0);
`endif
        advance();
        nop(); nop(); nop();

        // Load-use: lw x7 ; add x8,x7,x0
        set_id(LOAD, 5'd7, 5'd2, 5'd0, 1, 0, 0); step();
        set_id(ALU, 5'd8, 5'd7, 5'd0, 1, 1, 0); eval();
        check("ldu_c1_pc", pc_en, 0);
        check("ldu_c1_de", de_flush, 1);
        advance(); eval();
`ifdef HAZARD_FWD_EN
        check("ldu_c2_a", fwd_a, 2'd3);
        check("ldu_c2_pc", pc_en, 1);
`endif
        advance();
        nop(); nop(); nop();

        // Load to store data: lw x9 ; sw x9,0(x10)
        set_id(LOAD, 5'd9, 5'd2, 5'd0, 1, 0, 0); step();
        set_id(STORE, 5'd0, 5'd10, 5'd9, 1, 1, 0); eval();
`ifdef HAZARD_FWD_EN
        check("lds_pc", pc_en, 1);
        check("lds_b", fwd_b, 2'd0);
        advance();
        set_id(NONE, 0, 0, 0, 0, 0, 0); eval();
        check("lds_ls", fwd_ls, 1);
`endif
        advance();
        nop(); nop(); nop();

        // Stall with branch: lw x3 ; beq x3,x4
        set_id(LOAD, 5'd3, 5'd2, 5'd0, 1, 0, 0); step();
        set_id(NONE, 5'd0, 5'd3, 5'd4, 1, 1, 1); eval();
        check("br_c1_flush", fd_flush, 0);
        check("br_c1_pc", pc_en, 0);
        advance(); eval();
`ifdef HAZARD_FWD_EN
        check("br_c2_a", fwd_a, 2'd3);
        check("br_c2_flush", fd_flush, 1);
`endif
        advance();
        nop(); nop(); nop();

        // x0 producer: addi x0 ; add x1,x0,x0
        set_id(ALU, 5'd0, 5'd1, 5'd0, 1, 0, 0); step();
        set_id(ALU, 5'd1, 5'd0, 5'd0, 1, 1, 0); eval();
        check("x0_a", fwd_a, 0);
        check("x0_b", fwd_b, 0);
        check("x0_pc", pc_en, 1);
        advance();
        nop(); nop(); nop();

        // Async reset during a load-use stall
        set_id(LOAD, 5'd7, 5'd2, 5'd0, 1, 0, 0); step();
        set_id(ALU, 5'd8, 5'd7, 5'd0, 1, 0, 0); eval();
        check("rstmid_pre", pc_en, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_pc", pc_en, 1);
        check("rstmid_de", de_flush, 0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        eval();
        check("rstmid_after", pc_en, 1);
        advance();
        nop(); nop();

        // Randomized streams; a stalled ID instruction is held, as the core would.
        for (int i = 0; i < 400; i++) begin
            if (!e_stall) begin
                set_id(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) == 0));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detection and forwarding-control block for the five-stage RV32I core. Sits beside the ID stage, directly downstream of the instruction decoder, and consumes its `hazard_optype`, `rs1use` and `rs2use` outputs together with the ID-stage register indices. Keeps a registered record of the instructions in EX, MEM and WB. From that record it drives:
- PC and IF/ID enables;
- IF/ID and ID/EX flushes;
- ID-stage operand forwarding selects;
- the EX-stage store-data forward select.

## Interface
Parameters:
- `REG_AW`, 5: register index width.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hazard_optype_ID`  in  2  optype of the instruction in ID. Encodings: NONE 00, ALU 01, LOAD 10, STORE 11.
- `rd_ID`  in  REG_AW  destination register index of the ID instruction.
- `rs1_ID`, `rs2_ID`  in  REG_AW  source register indices of the ID instruction.
- `rs1use_ID`, `rs2use_ID`  in  1  source-register-used flags from the decoder.
- `Branch_ID`  in  1  redirect taken, resolved in ID.
- `PC_EN_IF`  out  1  PC update enable.
- `reg_FD_EN`  out  1  IF/ID register enable.
- `reg_FD_flush`  out  1  IF/ID register flush.
- `reg_DE_flush`  out  1  ID/EX register flush (inserts a bubble).
- `forward_ctrl_A`, `forward_ctrl_B`  out  2  ID operand source. Encodings: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- `forward_ctrl_ls`  out  1  store in EX takes its data from the MEM load data.

## Operation
- **Tracker:** three entries, EX, MEM and WB. Each entry holds `{optype[1:0], rd[REG_AW-1:0], ls_fwd}`.
- **rd = 0:** an entry with rd = 0 never matches any source register.
- **Match definition:** `hitS_X` is true when all of the following hold:
  - `rsS_useID` is 1;
  - `rsS_ID` is non-zero;
  - `rsS_ID` equals `X.rd`;
  - `X.optype` is ALU or LOAD.
- **Load-use stall:** `stall = (hit1_EX | hit2_EX) & EX.optype==LOAD`, with one exception. No stall is raised when ID is STORE, `hit2_EX` is set and `hit1_EX` is clear. This is the store-data case.
- **Forward selects, per operand, in priority order:**
  1. EX hit on ALU → 01.
  2. MEM hit on ALU → 10.
  3. MEM hit on LOAD → 11.
  4. Otherwise → 00.
  - The WB stage is never forwarded; the regfile writes before it reads.
  - In the store-data case, `forward_ctrl_B` is 00.
- **Stall outputs:** `PC_EN_IF = ~stall`, `reg_FD_EN = ~stall`, `reg_DE_flush = stall`.
- **Branch flush:** `reg_FD_flush = Branch_ID & ~stall`. A stall has priority because the branch was resolved on a stale operand.
- **Tracker advance, every clock edge, no global enable:**
  - WB ← MEM.
  - MEM ← EX.
  - EX ← {NONE, 0, 0} when stall.
  - Otherwise EX ← {hazard_optype_ID, rd_ID, store-data-case}.
  - For a STORE entry, rd is stored but never matches, because the match requires optype ALU or LOAD.
- **`forward_ctrl_ls`:** equals `EX.ls_fwd`. At that point the producing load sits in MEM.

## Timing
- **Reset (async assert, sync deassert by `rst_n`):**
  - All tracker entries clear to {NONE, 0, 0}.
  - Outputs at reset: `PC_EN_IF` = 1, `reg_FD_EN` = 1, both flushes 0, both `forward_ctrl` = 00, `forward_ctrl_ls` = 0.
- **Combinational outputs:** all outputs are combinational from the ID inputs and the registered tracker; zero-cycle latency within the ID cycle.
- **Load-use stall length:** exactly one cycle. In the next cycle the load sits in MEM and the consumer resolves to 11.
- **Back-to-back loads to the same rd:** each one produces at most a one-cycle stall.
- **Reset mid-stall:** the tracker is cleared and the stall is released immediately.

## Configuration
- **`HAZARD_FWD_EN` defined (default build):** full forwarding as specified above.
- **`HAZARD_FWD_EN` undefined:**
  - `forward_ctrl_A`, `forward_ctrl_B` and `forward_ctrl_ls` are tied to 0.
  - `ls_fwd` is never set.
  - `stall = hitS_EX | hitS_MEM` for any producer optype.
  - The consumer therefore waits until its producer reaches WB: two bubbles after an adjacent producer.

## Structure
- **Shared package `hazard_pkg`:**
  - optype localparams (NONE, ALU, LOAD, STORE);
  - forward-select localparams (REGF, EX_ALU, MEM_ALU, MEM_LD);
  - the tracker-entry packed layout.
- **One sub-module, `hazard_tracker`:**
  - the 3-entry shift register with async reset and bubble insertion;
  - exports the EX, MEM and WB entries.
- **Top level:** match, stall and forward logic is combinational.

## Test plan
- **ALU back-to-back:** `addi x5` followed by `add x6,x5,x5` → `forward_ctrl_A` = `forward_ctrl_B` = 01, no stall.
- **Load-use:** `lw x7` followed by `add x8,x7,x0`:
  - cycle 1: `stall` = 1, `PC_EN_IF` = 0, `reg_DE_flush` = 1;
  - cycle 2: `forward_ctrl_A` = 11, `stall` = 0.
- **Load-to-store data:** `lw x9` followed by `sw x9,0(x10)`:
  - no stall, `forward_ctrl_B` = 00;
  - one cycle later, `forward_ctrl_ls` = 1.
- **Stall with branch:** `lw x3` followed by `beq x3,x4` with `Branch_ID` = 1:
  - cycle 1: `reg_FD_flush` = 0, stall asserted;
  - cycle 2: MEM-LOAD forward gives `forward_ctrl_A` = 11; `reg_FD_flush` = 1.
- **x0 producer:** `addi x0` followed by `add x1,x0,x0` → both forward selects 00, no stall.
- **Forwarding disabled:** without `HAZARD_FWD_EN`, `addi x5` followed by `add x6,x5,x0` → two stall cycles, then selects 00.
- **Async reset mid-stall:** `rst_n` low during a load-use stall → `PC_EN_IF` = 1 immediately, tracker cleared.
